// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM bus bundle for mem_port_arbiter.
// slave: arbiter side, master: requester/SRAM side.
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 6,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_r_en;
  logic [N_REQ-1:0]        req_w_en;
  logic [N_REQ*ADDR_W-1:0] req_ptr;
  logic [N_REQ*ADDR_W-1:0] req_region_begin;
  logic [N_REQ*ADDR_W-1:0] req_region_end;
  logic [N_REQ*DATA_W-1:0] req_data_store;
  logic [DATA_W-1:0]       req_data_load;
  logic [N_REQ-1:0]        req_done;
  logic [N_REQ-1:0]        req_err;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_re;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;
  logic [IDW-1:0]          grant_id;

  modport slave (
    input  req_r_en, req_w_en, req_ptr,
    input  req_region_begin, req_region_end,
    input  req_data_store, mem_rdata,
    output req_data_load, req_done, req_err,
    output mem_addr, mem_re, mem_we, mem_wdata,
    output busy, grant_id
  );

  modport master (
    output req_r_en, req_w_en, req_ptr,
    output req_region_begin, req_region_end,
    output req_data_store, mem_rdata,
    input  req_data_load, req_done, req_err,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N_REQ requesters.
// Ports: clk, rst (async high), bus (slave: req_*, mem_*, busy, grant_id).
module mem_port_arbiter #(
  parameter int N_REQ   = 6,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = 8;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_e;

  state_e            state_q;
  logic [IDW-1:0]    rp_q;
  logic [IDW-1:0]    grant_q;
  logic              rd_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              re_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_q;
  logic [N_REQ-1:0]  done_q;
  logic [N_REQ-1:0]  errv_q;
  logic              busy_q;

  logic [N_REQ-1:0]  act;
  logic              sel_vld;
  logic [IDW-1:0]    sel_idx;
  logic [IDW-1:0]    rp_d;
  logic              sel_r;
  logic              sel_w;
  logic [ADDR_W-1:0] sel_ptr;
  logic [ADDR_W-1:0] sel_beg;
  logic [ADDR_W-1:0] sel_end;
  logic [ADDR_W-1:0] sel_span;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_st;
  logic              sel_err;
  int                j;

  // First active requester at or after rp, cyclic.
  always_comb begin
    act     = bus.req_r_en | bus.req_w_en;
    sel_vld = 1'b0;
    sel_idx = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rp_q) + k) % N_REQ;
      if (!sel_vld && act[j]) begin
        sel_vld = 1'b1;
        sel_idx = IDW'(j);
      end
    end
  end

  // Address and bounds are resolved from the held operands in IDLE so
  // that the ISSUE-cycle strobes come straight out of registers.
  always_comb begin
    rp_d     = (int'(sel_idx) == N_REQ-1) ? '0 : sel_idx + 1'b1;
    sel_r    = bus.req_r_en[sel_idx];
    sel_w    = bus.req_w_en[sel_idx];
    sel_ptr  = bus.req_ptr[sel_idx*ADDR_W +: ADDR_W];
    sel_beg  = bus.req_region_begin[sel_idx*ADDR_W +: ADDR_W];
    sel_end  = bus.req_region_end[sel_idx*ADDR_W +: ADDR_W];
    sel_st   = bus.req_data_store[sel_idx*DATA_W +: DATA_W];
    sel_span = sel_end - sel_beg;
    sel_addr = sel_beg + sel_ptr;
    sel_err  = (sel_ptr >= sel_span)
             | (sel_end < sel_beg)
             | (sel_r & sel_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rp_q    <= '0;
      grant_q <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      load_q  <= '0;
      done_q  <= '0;
      errv_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= '0;
      errv_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            grant_q <= sel_idx;
            rp_q    <= rp_d;
            rd_q    <= sel_r;
            err_q   <= sel_err;
            if (!sel_err) begin
              addr_q <= sel_addr;
              re_q   <= sel_r;
              we_q   <= sel_w;
              if (sel_w) wdata_q <= sel_st;
            end
          end
        end
        S_ISSUE: begin
          if (err_q || !rd_q) begin
            state_q         <= S_DONE;
            done_q[grant_q] <= 1'b1;
            errv_q[grant_q] <= err_q;
          end else if (MEM_LAT == 1) begin
            state_q         <= S_DONE;
            done_q[grant_q] <= 1'b1;
            load_q          <= bus.mem_rdata;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == CW'(MEM_LAT-2)) begin
            state_q         <= S_DONE;
            done_q[grant_q] <= 1'b1;
            load_q          <= bus.mem_rdata;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_re        = re_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.req_data_load = load_q;
  assign bus.req_done      = done_q;
  assign bus.req_err       = errv_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, fairness,
// reset-abort and a scoreboard of expected SRAM accesses and done pulses.
module tb_mem_port_arbiter;
  localparam int N  = 6;
  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    int          idx;
    bit          r;
    bit          w;
    logic [15:0] rb;
    logic [15:0] re;
    logic [15:0] ptr;
    logic [31:0] st;
    bit          err;
    logic [15:0] addr;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    bit          we;
    logic [31:0] wd;
  } mexp_t;

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] data;
  } dexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cyc = 0;

  mexp_t exp_mem[$];
  dexp_t exp_done[$];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd = '0;
  vec_t vecs[10];

  logic [31:0] sram [65536];
  bit          wr_v [65536];
  logic [31:0] rd_q = '0;

  mem_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int a);
    if (a == 103) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  // Synchronous SRAM: data appears the cycle after the strobe (MEM_LAT=2).
  always @(posedge clk) begin
    if (bus.mem_we) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
      wr_v[bus.mem_addr] <= 1'b1;
    end
    if (bus.mem_re)
      rd_q <= wr_v[bus.mem_addr] ? sram[bus.mem_addr]
                                 : pat(int'(bus.mem_addr));
  end
  assign bus.mem_rdata = rd_q;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    mexp_t m;
    dexp_t d;
    logic [N-1:0] e;
    if (!rst) begin
      if (bus.mem_re || bus.mem_we) begin
        strobe_cyc = cyc;
        if (exp_mem.size() == 0) begin
          chk("unexp_mem", {62'd0, bus.mem_re, bus.mem_we}, 64'd0);
        end else begin
          m = exp_mem.pop_front();
          chk("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
          chk("mem_we", 64'(bus.mem_we), 64'(m.we));
          chk("mem_re", 64'(bus.mem_re), 64'(!m.we));
          if (m.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(m.wd));
        end
      end
      if (|bus.req_done) begin
        if (exp_done.size() == 0) begin
          chk("unexp_done", 64'(bus.req_done), 64'd0);
        end else begin
          d = exp_done.pop_front();
          e = '0;
          e[d.idx] = d.err;
          chk("done_onehot", 64'(bus.req_done), 64'(1) << d.idx);
          chk("err", 64'(bus.req_err), 64'(e));
          chk("grant_id", 64'(bus.grant_id), 64'(d.idx));
          chk("data_load", 64'(bus.req_data_load), 64'(d.data));
        end
      end
    end
  end

  task automatic clr_req();
    bus.req_r_en = '0;
    bus.req_w_en = '0;
  endtask

  task automatic set_req(input int i, input bit r, input bit w,
                         input logic [15:0] rb, input logic [15:0] re,
                         input logic [15:0] p, input logic [31:0] st);
    bus.req_r_en[i] = r;
    bus.req_w_en[i] = w;
    bus.req_region_begin[i*AW +: AW] = rb;
    bus.req_region_end[i*AW +: AW]   = re;
    bus.req_ptr[i*AW +: AW]          = p;
    bus.req_data_store[i*DW +: DW]   = st;
  endtask

  // Expected outcome of one transaction, from the bench's own memory copy.
  task automatic push_exp(input int i, input bit r, input bit w,
                          input bit err, input logic [15:0] a,
                          input logic [31:0] st);
    dexp_t d;
    if (!err) exp_mem.push_back('{addr: a, we: w, wd: st});
    d.idx = i;
    d.err = err;
    if (!err && r) last_rd = ref_rd(int'(a));
    d.data = last_rd;
    if (!err && w) ref_mem[int'(a)] = st;
    exp_done.push_back(d);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    bit got;
    @(negedge clk);
    push_exp(v.idx, v.r, v.w, v.err, v.addr, v.st);
    set_req(v.idx, v.r, v.w, v.rb, v.re, v.ptr, v.st);
    t0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (|bus.req_done) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      chk("latency", 64'(cyc - t0), 64'(v.lat));
      chk("busy_done", 64'(bus.busy), 64'd1);
      if (!v.err) chk("strobe_cyc", 64'(strobe_cyc - t0), 64'd1);
    end
    clr_req();
    @(negedge clk);
    chk("busy_idle", 64'(bus.busy), 64'd0);
  endtask

  task automatic wait_dones(input int n, input int budget,
                            output int seen);
    seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      @(negedge clk);
      if (|bus.req_done) seen++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int fl[3];
    fl = '{0, 3, 5};

    //  idx r w  begin     end       ptr      store      err addr  lat
    vecs[0] = '{2, 1, 0, 16'd100, 16'd125, 16'd3, 32'h0, 0, 16'd103, 3};
    vecs[1] = '{0, 0, 1, 16'd0, 16'd25, 16'd24, 32'h15, 0, 16'd24, 2};
    vecs[2] = '{1, 1, 0, 16'd10, 16'd20, 16'd10, 32'h0, 1, 16'd0, 2};
    vecs[3] = '{1, 1, 1, 16'd10, 16'd20, 16'd2, 32'h77, 1, 16'd0, 2};
    vecs[4] = '{3, 0, 1, 16'hFFF0, 16'hFFFF, 16'd4, 32'hA5A5, 0,
                16'hFFF4, 2};
    vecs[5] = '{3, 1, 0, 16'hFFF0, 16'hFFFF, 16'd4, 32'h0, 0,
                16'hFFF4, 3};
    vecs[6] = '{5, 1, 0, 16'd50, 16'd40, 16'd0, 32'h0, 1, 16'd0, 2};
    vecs[7] = '{4, 1, 0, 16'hFFF0, 16'hFFFF, 16'd14, 32'h0, 0,
                16'hFFFE, 3};
    vecs[8] = '{5, 0, 1, 16'd0, 16'd25, 16'd25, 32'h9, 1, 16'd0, 2};
    vecs[9] = '{2, 1, 0, 16'd100, 16'd125, 16'd24, 32'h0, 0,
                16'd124, 3};

    bus.req_r_en = '0;
    bus.req_w_en = '0;
    bus.req_ptr = '0;
    bus.req_region_begin = '0;
    bus.req_region_end = '0;
    bus.req_data_store = '0;

    // Fairness: 0, 3, 5 hold writes from reset.
    foreach (fl[i])
      set_req(fl[i], 1'b0, 1'b1, 16'(fl[i]*16), 16'(fl[i]*16+16),
              16'd1, 32'h100 + 32'(fl[i]));
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_re", 64'(bus.mem_re), 64'd0);
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_done", 64'(bus.req_done), 64'd0);
    chk("rst_err", 64'(bus.req_err), 64'd0);
    chk("rst_load", 64'(bus.req_data_load), 64'd0);
    chk("rst_gid", 64'(bus.grant_id), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    for (int r = 0; r < 2; r++)
      foreach (fl[i])
        push_exp(fl[i], 1'b0, 1'b1, 1'b0, 16'(fl[i]*16+1),
                 32'h100 + 32'(fl[i]));
    rst = 1'b0;
    wait_dones(6, 80, n);
    chk("fair_dones", 64'(n), 64'd6);
    clr_req();
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during WAIT aborts the read; rp restarts at 0 afterwards.
    @(negedge clk);
    exp_mem.push_back('{addr: 16'd205, we: 1'b0, wd: 32'h0});
    set_req(4, 1'b1, 1'b0, 16'd200, 16'd300, 16'd5, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_re", 64'(bus.mem_re), 64'd0);
    chk("abort_done", 64'(bus.req_done), 64'd0);
    chk("abort_gid", 64'(bus.grant_id), 64'd0);
    chk("abort_load", 64'(bus.req_data_load), 64'd0);
    last_rd = '0;
    set_req(5, 1'b1, 1'b0, 16'd300, 16'd400, 16'd7, 32'h0);
    push_exp(4, 1'b1, 1'b0, 1'b0, 16'd205, 32'h0);
    push_exp(5, 1'b1, 1'b0, 1'b0, 16'd307, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_dones(1, 20, n);
    chk("post_rst_first", 64'(n), 64'd1);
    bus.req_r_en[4] = 1'b0;
    wait_dones(1, 20, n);
    chk("post_rst_second", 64'(n), 64'd1);
    clr_req();
    repeat (3) @(negedge clk);

    chk("mem_q_left", 64'(exp_mem.size()), 64'd0);
    chk("done_q_left", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
